// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder BIST checker.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StCheck,
    StDone
  } state_e;

  // Width of the mismatch counter and its saturation value.
  localparam int unsigned ErrW = 16;
  localparam logic [ErrW-1:0] ErrSat = 16'hFFFF;

  // Settle counter width; holds SETTLE values up to 15.
  localparam int unsigned CntW = 4;

endpackage

// File: rtl/adder_bist_checker_if.sv
// Stimulus/response bundle between the BIST checker and the adder under test.
interface adder_bist_checker_if #(
  parameter int unsigned WIDTH = 1
);
  logic [WIDTH-1:0] dut_a;
  logic [WIDTH-1:0] dut_b;
  logic             dut_cin;
  logic [WIDTH-1:0] dut_sum;
  logic             dut_cout;

  // The checker drives operands and reads back the result.
  modport master (
    output dut_a,
    output dut_b,
    output dut_cin,
    input  dut_sum,
    input  dut_cout
  );

  // The adder under test.
  modport slave (
    input  dut_a,
    input  dut_b,
    input  dut_cin,
    output dut_sum,
    output dut_cout
  );
endinterface

// File: rtl/adder_vec_gen.sv
// Vector index counter; splits the index into registered {a, b, cin} operands.
module adder_vec_gen #(
  parameter int unsigned WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               advance,
  output logic [WIDTH-1:0]   dut_a,
  output logic [WIDTH-1:0]   dut_b,
  output logic               dut_cin,
  output logic [2*WIDTH:0]   vec_idx,
  output logic               last_vec
);

  logic [2*WIDTH:0] idx_q;

  // Index register: load returns to vector 0, advance steps to the next vector.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      idx_q <= '0;
    end else if (advance) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  // cin is the LSB, a occupies the MSBs.
  assign dut_a    = idx_q[2*WIDTH:WIDTH+1];
  assign dut_b    = idx_q[WIDTH:1];
  assign dut_cin  = idx_q[0];
  assign vec_idx  = idx_q;
  assign last_vec = &idx_q;

endmodule

// File: rtl/adder_bist_checker.sv
// Exhaustive BIST engine for a WIDTH-bit adder: drives every vector, waits SETTLE
// cycles, compares against a golden sum and reports a pass/fail verdict.
module adder_bist_checker
  import adder_bist_pkg::*;
#(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  adder_bist_checker_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ErrW-1:0]      err_count,
  output logic [2*WIDTH:0]     first_fail_vec,
  output logic                 fail_valid
);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [ErrW-1:0]   err_q, err_d;
  logic              pass_q, pass_d;
  logic [2*WIDTH:0]  ffv_q, ffv_d;
  logic              fv_q, fv_d;

  logic              vec_load;
  logic              vec_adv;
  logic [WIDTH-1:0]  vec_a;
  logic [WIDTH-1:0]  vec_b;
  logic              vec_cin;
  logic [2*WIDTH:0]  vec_idx;
  logic              last_vec;

  logic [WIDTH:0]    golden;
  logic              mismatch;

  adder_vec_gen #(
    .WIDTH (WIDTH)
  ) u_vec_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (vec_load),
    .advance  (vec_adv),
    .dut_a    (vec_a),
    .dut_b    (vec_b),
    .dut_cin  (vec_cin),
    .vec_idx  (vec_idx),
    .last_vec (last_vec)
  );

  assign bus.dut_a   = vec_a;
  assign bus.dut_b   = vec_b;
  assign bus.dut_cin = vec_cin;

  // Golden result is computed from the operands actually being driven.
  assign golden   = {1'b0, vec_a} + {1'b0, vec_b} + {{WIDTH{1'b0}}, vec_cin};
  assign mismatch = (golden != {bus.dut_cout, bus.dut_sum});

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      ffv_q   <= '0;
      fv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      ffv_q   <= ffv_d;
      fv_q    <= fv_d;
    end
  end

  // Next-state, settle timing, comparison and error bookkeeping.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    pass_d   = pass_q;
    ffv_d    = ffv_q;
    fv_d     = fv_q;
    vec_load = 1'b0;
    vec_adv  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StSettle;
          vec_load = 1'b1;
          cnt_d    = CntW'(SETTLE);
          err_d    = '0;
          pass_d   = 1'b0;
          ffv_d    = '0;
          fv_d     = 1'b0;
        end
      end
      StSettle: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (mismatch) begin
          if (err_q != ErrSat) begin
            err_d = err_q + 1'b1;
          end
          if (!fv_q) begin
            fv_d  = 1'b1;
            ffv_d = vec_idx;
          end
        end
        if (last_vec) begin
          // Park operands at zero for the done cycle; the index never wraps in-run.
          state_d  = StDone;
          vec_load = 1'b1;
          pass_d   = (err_d == '0);
        end else begin
          state_d = StSettle;
          vec_adv = 1'b1;
          cnt_d   = CntW'(SETTLE);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy           = (state_q == StSettle) || (state_q == StCheck);
  assign done           = (state_q == StDone);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_vec = ffv_q;
  assign fail_valid     = fv_q;

endmodule

// File: tb/tb_adder_bist_checker.sv
// Directed bench for adder_bist_checker with several adder models.
module tb_adder_bist_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] start_v;
  logic       cout_stuck;

  int n_total = 0;
  int n_bad   = 0;
  int done_cnt0 = 0;

  always #5 clk = ~clk;

  adder_bist_checker_if #(.WIDTH(1)) bus0 ();
  adder_bist_checker_if #(.WIDTH(2)) bus1 ();
  adder_bist_checker_if #(.WIDTH(1)) bus2 ();
  adder_bist_checker_if #(.WIDTH(1)) bus3 ();

  // DUT0: correct 1-bit adder, carry-out optionally stuck at 0.
  logic [1:0] sum0_full;
  assign sum0_full     = {1'b0, bus0.dut_a} + {1'b0, bus0.dut_b} + {1'b0, bus0.dut_cin};
  assign bus0.dut_sum  = sum0_full[0];
  assign bus0.dut_cout = cout_stuck ? 1'b0 : sum0_full[1];

  // DUT1: 2-bit adder with sum[0] inverted.
  logic [2:0] sum1_full;
  assign sum1_full     = {1'b0, bus1.dut_a} + {1'b0, bus1.dut_b} + {2'b00, bus1.dut_cin};
  assign bus1.dut_sum  = sum1_full[1:0] ^ 2'b01;
  assign bus1.dut_cout = sum1_full[2];

  // DUT2/DUT3: 1-bit adder with two registered stages of latency.
  logic [1:0] l2_r1, l2_r2, l3_r1, l3_r2;
  always @(posedge clk) begin
    l2_r1 <= {1'b0, bus2.dut_a} + {1'b0, bus2.dut_b} + {1'b0, bus2.dut_cin};
    l2_r2 <= l2_r1;
    l3_r1 <= {1'b0, bus3.dut_a} + {1'b0, bus3.dut_b} + {1'b0, bus3.dut_cin};
    l3_r2 <= l3_r1;
  end
  assign bus2.dut_sum  = l2_r2[0];
  assign bus2.dut_cout = l2_r2[1];
  assign bus3.dut_sum  = l3_r2[0];
  assign bus3.dut_cout = l3_r2[1];

  logic        busy0, done0, pass0, fv0;
  logic [15:0] err0;
  logic [2:0]  ffv0;
  logic        busy1, done1, pass1, fv1;
  logic [15:0] err1;
  logic [4:0]  ffv1;
  logic        busy2, done2, pass2, fv2;
  logic [15:0] err2;
  logic [2:0]  ffv2;
  logic        busy3, done3, pass3, fv3;
  logic [15:0] err3;
  logic [2:0]  ffv3;
  logic [3:0]  done_v;

  assign done_v = {done3, done2, done1, done0};

  adder_bist_checker #(.WIDTH(1), .SETTLE(1)) u_dut0 (
    .clk (clk), .rst (rst), .start (start_v[0]), .bus (bus0),
    .busy (busy0), .done (done0), .pass (pass0), .err_count (err0),
    .first_fail_vec (ffv0), .fail_valid (fv0)
  );

  adder_bist_checker #(.WIDTH(2), .SETTLE(1)) u_dut1 (
    .clk (clk), .rst (rst), .start (start_v[1]), .bus (bus1),
    .busy (busy1), .done (done1), .pass (pass1), .err_count (err1),
    .first_fail_vec (ffv1), .fail_valid (fv1)
  );

  adder_bist_checker #(.WIDTH(1), .SETTLE(1)) u_dut2 (
    .clk (clk), .rst (rst), .start (start_v[2]), .bus (bus2),
    .busy (busy2), .done (done2), .pass (pass2), .err_count (err2),
    .first_fail_vec (ffv2), .fail_valid (fv2)
  );

  adder_bist_checker #(.WIDTH(1), .SETTLE(3)) u_dut3 (
    .clk (clk), .rst (rst), .start (start_v[3]), .bus (bus3),
    .busy (busy3), .done (done3), .pass (pass3), .err_count (err3),
    .first_fail_vec (ffv3), .fail_valid (fv3)
  );

  always @(posedge clk) begin
    if (done0) done_cnt0 <= done_cnt0 + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle and count cycles until done (start edge ends cycle 0).
  task automatic run_to_done(input int idx, input int bound, output int cyc);
    start_v[idx] = 1'b1;
    cyc = 0;
    do begin
      step();
      start_v[idx] = 1'b0;
      cyc++;
    end while (!done_v[idx] && cyc < bound);
  endtask

  initial begin
    int cyc;
    int d_before;

    rst        = 1'b1;
    start_v    = 4'b0;
    cout_stuck = 1'b0;
    repeat (3) step();

    // Reset values.
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_pass", pass0, 0);
    check("rst_err", err0, 0);
    check("rst_ffv", ffv0, 0);
    check("rst_fv", fv0, 0);
    check("rst_vec", {bus0.dut_a, bus0.dut_b, bus0.dut_cin}, 0);
    rst = 1'b0;
    step();

    // Correct adder, WIDTH=1, SETTLE=1.
    run_to_done(0, 100, cyc);
    check("good_cycles", cyc, 17);
    check("good_busy_in_done", busy0, 0);
    check("good_pass", pass0, 1);
    check("good_err", err0, 0);
    check("good_fv", fv0, 0);
    check("good_vec_parked", {bus0.dut_a, bus0.dut_b, bus0.dut_cin}, 0);
    step();
    check("good_done_pulse", done0, 0);
    check("good_pass_held", pass0, 1);

    // Carry-out stuck at 0: vectors 3,5,6,7 fail.
    cout_stuck = 1'b1;
    run_to_done(0, 100, cyc);
    check("stuck_cycles", cyc, 17);
    check("stuck_err", err0, 4);
    check("stuck_ffv", ffv0, 3);
    check("stuck_fv", fv0, 1);
    check("stuck_pass", pass0, 0);

    // WIDTH=2 with sum[0] inverted: all 32 vectors fail.
    run_to_done(1, 200, cyc);
    check("inv_cycles", cyc, 65);
    check("inv_err", err1, 32);
    check("inv_ffv", ffv1, 0);
    check("inv_fv", fv1, 1);
    check("inv_pass", pass1, 0);

    // Reset mid-run while v=4 is settling (cycle 9).
    start_v[0] = 1'b1;
    cyc = 0;
    while (cyc < 9) begin
      step();
      start_v[0] = 1'b0;
      cyc++;
    end
    check("mid_vec4", {bus0.dut_a, bus0.dut_b, bus0.dut_cin}, 3'b100);
    check("mid_busy", busy0, 1);
    check("mid_err", err0, 1);
    check("mid_fv", fv0, 1);
    d_before = done_cnt0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrst_busy", busy0, 0);
    check("midrst_err", err0, 0);
    check("midrst_ffv", ffv0, 0);
    check("midrst_fv", fv0, 0);
    check("midrst_vec", {bus0.dut_a, bus0.dut_b, bus0.dut_cin}, 0);
    repeat (20) step();
    check("midrst_no_done", done_cnt0 - d_before, 0);
    cout_stuck = 1'b0;
    run_to_done(0, 100, cyc);
    check("after_rst_cycles", cyc, 17);
    check("after_rst_pass", pass0, 1);

    // Two-cycle latency adder: SETTLE=1 sees the previous vector's sum.
    run_to_done(2, 100, cyc);
    check("lat1_cycles", cyc, 17);
    check("lat1_pass", pass2, 0);
    check("lat1_err", err2, 5);
    check("lat1_ffv", ffv2, 1);
    run_to_done(3, 100, cyc);
    check("lat3_cycles", cyc, 33);
    check("lat3_pass", pass3, 1);
    check("lat3_err", err3, 0);

    // Extra start pulses mid-run (SETTLE and final CHECK) are ignored.
    cout_stuck = 1'b1;
    d_before = done_cnt0;
    start_v[0] = 1'b1;
    cyc = 0;
    do begin
      step();
      cyc++;
      start_v[0] = (cyc == 5 || cyc == 16);
    end while (!done0 && cyc < 100);
    start_v[0] = 1'b0;
    check("restart_cycles", cyc, 17);
    check("restart_err", err0, 4);
    check("restart_ffv", ffv0, 3);
    repeat (10) step();
    check("restart_one_done", done_cnt0 - d_before, 1);
    check("restart_idle", busy0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/adder_bist_checker.md
# adder_bist_checker

Hardware built-in self-test (BIST) engine for the adder blocks: `full_adder` and its ripple-carry extensions.
- Drives every input combination of a WIDTH-bit adder under test in order.
- Waits a programmable settle time, then samples the adder's sum and carry-out.
- Compares the result against an internal golden sum, counts mismatches and reports a single pass/fail verdict.

It is the checking end of the adder stimulus interface and sits beside the adder in synthesized designs, for on-silicon or FPGA self-test.

## Interface
Parameters:
- WIDTH, 1, operand width of the adder under test (legal range 1..8)
- SETTLE, 1, cycles each vector is held before sampling (legal range 1..15)

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a test run; sampled only in IDLE
- dut_a  out  WIDTH  operand A to adder, registered
- dut_b  out  WIDTH  operand B to adder, registered
- dut_cin  out  1  carry-in to adder, registered
- dut_sum  in  WIDTH  sum from adder
- dut_cout  in  1  carry-out from adder
- busy  out  1  high from the start edge until the DONE state is entered
- done  out  1  one-cycle pulse at end of run
- pass  out  1  high when the last run had zero mismatches; held until the next start
- err_count  out  16  mismatch count of the current/last run, saturates at 16'hFFFF
- first_fail_vec  out  2*WIDTH+1  index of the first failing vector
- fail_valid  out  1  first_fail_vec holds a valid index

## Operation
- Vector index v is 2*WIDTH+1 bits wide and decodes as {dut_a, dut_b, dut_cin} = v: cin is the LSB, a occupies the MSBs.
- A run covers v = 0 .. 2^(2*WIDTH+1)-1 in ascending order, once each.
- Golden result is WIDTH+1 bits: zero-extended dut_a + dut_b + dut_cin.
- The golden result is compared with {dut_cout, dut_sum}; any difference is a mismatch.

FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE → SETTLE on start:
  - v=0 is loaded onto dut_*.
  - settle counter is loaded with SETTLE.
  - err_count, pass, fail_valid and first_fail_vec are cleared.
- SETTLE:
  - the settle counter decrements each cycle.
  - the state lasts exactly SETTLE cycles, then moves to CHECK.
- CHECK (one cycle):
  - the comparison is evaluated.
  - on a mismatch, err_count increments (saturating).
  - if fail_valid=0, first_fail_vec is set to v and fail_valid is set to 1.
  - if v is not the last vector: v+1 is driven, the settle counter is reloaded, and the FSM returns to SETTLE.
  - if v is the last vector: the FSM moves to DONE.
- DONE (one cycle):
  - done=1.
  - pass = (err_count==0), with the final CHECK result included.
  - dut_* return to 0.
  - the FSM moves to IDLE.

Boundary rules:
- start while in SETTLE, CHECK or DONE is ignored; no restart and no counter effect.
- start held high continuously gives back-to-back runs: a new run begins on the first IDLE cycle.
- The counter wrap at the last vector never re-drives v=0 within the same run.
- err_count saturates at 16'hFFFF.
- rst at any cycle, including mid-run, forces IDLE and all reset values at the next edge; no done pulse is produced.

## Timing
- Reset values: dut_a=0, dut_b=0, dut_cin=0, busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, fail_valid=0.
- dut_* change only on clock edges; each vector is stable for SETTLE+1 cycles.
- The adder output is sampled at the CHECK edge, SETTLE+1 cycles after the vector was driven.
- Run length: the start edge is cycle 0; done is high during cycle N*(SETTLE+1)+1, where N = 2^(2*WIDTH+1).
- busy is high for cycles 1 .. N*(SETTLE+1) and low in the done cycle.
- pass, err_count and first_fail_vec are final and stable from the done cycle until the next start edge.

## Structure
- Shared package adder_bist_pkg contains:
  - the state enum (IDLE, SETTLE, CHECK, DONE);
  - the err_count width constant (16);
  - the saturation value.
- One sub-module, adder_vec_gen, holds the vector index counter and the {a,b,cin} split.
  - Inputs: load, advance.
  - Outputs: the registered dut_* values and a last-vector flag.
- The FSM, settle counter, comparator and error bookkeeping live in adder_bist_checker.

## Test plan
- Correct behavioral adder, WIDTH=1, SETTLE=1 → done in cycle 17 after start, pass=1, err_count=0, fail_valid=0.
- dut_cout stuck at 0, WIDTH=1 → err_count=4 (failing v=3,5,6,7), first_fail_vec=3'b011, fail_valid=1, pass=0.
- WIDTH=2 with dut_sum[0] inverted → err_count=32, first_fail_vec=0, pass=0.
- rst asserted for one cycle while v=4 in SETTLE:
  - all outputs take reset values next edge and no done pulse occurs;
  - a following start completes normally with pass=1.
- Adder model with 2-cycle registered latency:
  - SETTLE=1 → pass=0;
  - SETTLE=3 → pass=1.
- start pulsed again mid-run → exactly one done pulse; err_count and timing identical to the single-start run.
